// File: rtl/ps2_scancodes_pkg.sv
// PS/2 Set-2 scan-code constants, decoder state encoding and key-slot lookup.
// Shared by the key decoder and any future keyboard-menu logic.
package ps2_scancodes_pkg;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam logic [7:0] KEY_W      = 8'h1D;
    localparam logic [7:0] KEY_S      = 8'h1B;
    localparam logic [7:0] KEY_UP     = 8'h75;  // extended (E0 prefix)
    localparam logic [7:0] KEY_DN     = 8'h72;  // extended (E0 prefix)
    localparam logic [7:0] KEY_SPACE  = 8'h29;
    localparam logic [7:0] KEY_ESC    = 8'h76;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    localparam int         NUM_SLOTS  = 6;
    localparam logic [2:0] SLOT_W     = 3'd0;
    localparam logic [2:0] SLOT_S     = 3'd1;
    localparam logic [2:0] SLOT_UP    = 3'd2;
    localparam logic [2:0] SLOT_DN    = 3'd3;
    localparam logic [2:0] SLOT_SPACE = 3'd4;
    localparam logic [2:0] SLOT_ESC   = 3'd5;
    localparam logic [2:0] SLOT_NONE  = 3'd7;

    // Arrow codes only count with the E0 prefix; plain keys only without it.
    function automatic logic [2:0] key_slot(input logic [7:0] code, input logic ext);
        logic [2:0] slot;
        slot = SLOT_NONE;
        if (ext) begin
            if (code == KEY_UP)      slot = SLOT_UP;
            else if (code == KEY_DN) slot = SLOT_DN;
        end else begin
            if (code == KEY_W)          slot = SLOT_W;
            else if (code == KEY_S)     slot = SLOT_S;
            else if (code == KEY_SPACE) slot = SLOT_SPACE;
            else if (code == KEY_ESC)   slot = SLOT_ESC;
        end
        return slot;
    endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 Set-2 scan-code bytes into held-key levels for two players and
// typematic-free start/pause pulses, with a timeout on dangling prefixes.
module ps2_key_decoder
    import ps2_scancodes_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       CLK,
    input  logic       RST_BTN,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       start_pulse,
    output logic       pause_pulse,
    output logic       seq_error
);

    localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    kbd_state_t           state_reg, state_next;
    logic [NUM_SLOTS-1:0] held_reg, held_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 start_next, pause_next, err_next;
    logic                 in_ext, in_brk;
    logic [2:0]           slot;

    assign in_ext = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
    assign in_brk = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);
    assign slot   = key_slot(byte_data, in_ext);

    always_comb begin
        state_next = state_reg;
        held_next  = held_reg;
        cnt_next   = cnt_reg;
        start_next = 1'b0;
        pause_next = 1'b0;
        err_next   = 1'b0;
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (byte_valid) begin
            cnt_next = '0;
            if (byte_data == PREFIX_EXT) begin
                state_next = ST_EXT;
            end else if (byte_data == PREFIX_BRK) begin
                state_next = in_ext ? ST_EXT_BRK : ST_BRK;
            end else begin
                state_next = ST_IDLE;
                if (slot != SLOT_NONE) begin
                    if (in_brk) begin
                        held_next[slot] = 1'b0;
                    end else begin
                        held_next[slot] = 1'b1;
                        start_next = (slot == SLOT_SPACE) && !held_reg[SLOT_SPACE];
                        pause_next = (slot == SLOT_ESC) && !held_reg[SLOT_ESC];
                    end
                end
            end
        end else if (state_reg != ST_IDLE) begin
            if (cnt_reg == CNT_LAST) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                err_next   = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end else begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state_reg   <= ST_IDLE;
            held_reg    <= '0;
            cnt_reg     <= '0;
            p1_up       <= 1'b0;
            p1_down     <= 1'b0;
            p2_up       <= 1'b0;
            p2_down     <= 1'b0;
            start_pulse <= 1'b0;
            pause_pulse <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            held_reg    <= held_next;
            cnt_reg     <= cnt_next;
            // Opposing directions held together cancel out.
            p1_up       <= held_next[SLOT_W]  && !held_next[SLOT_S];
            p1_down     <= held_next[SLOT_S]  && !held_next[SLOT_W];
            p2_up       <= held_next[SLOT_UP] && !held_next[SLOT_DN];
            p2_down     <= held_next[SLOT_DN] && !held_next[SLOT_UP];
            start_pulse <= start_next;
            pause_pulse <= pause_next;
            seq_error   <= err_next;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised and directed check of ps2_key_decoder against a prefix-flag
// reference model of the scan-code protocol.
module tb_ps2_key_decoder;

    localparam int T = 40;

    logic       CLK = 1'b0;
    logic       RST_BTN = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       p1_up, p1_down, p2_up, p2_down, start_pulse, pause_pulse, seq_error;

    ps2_key_decoder #(.TIMEOUT_CYC(T)) dut (
        .CLK(CLK), .RST_BTN(RST_BTN), .byte_data(byte_data), .byte_valid(byte_valid),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .start_pulse(start_pulse), .pause_pulse(pause_pulse), .seq_error(seq_error)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending-prefix flags, held map, idle-cycle count.
    bit m_ext, m_brk;
    int m_idle;
    bit m_held[string];
    bit e_start, e_pause, e_err;
    int n_start, n_pause, n_err;

    function automatic string key_name(input logic [7:0] b, input bit ext);
        if (ext && b == 8'h75) return "UP";
        if (ext && b == 8'h72) return "DN";
        if (!ext && b == 8'h1D) return "W";
        if (!ext && b == 8'h1B) return "S";
        if (!ext && b == 8'h29) return "SPACE";
        if (!ext && b == 8'h76) return "ESC";
        return "";
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_idle = 0;
        m_held["W"] = 0; m_held["S"] = 0; m_held["UP"] = 0;
        m_held["DN"] = 0; m_held["SPACE"] = 0; m_held["ESC"] = 0;
        e_start = 0; e_pause = 0; e_err = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        string k;
        e_start = 0; e_pause = 0; e_err = 0;
        if (v) begin
            m_idle = 0;
            if (b == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else begin
                k = key_name(b, m_ext);
                if (k != "") begin
                    if (m_brk) m_held[k] = 0;
                    else begin
                        if (k == "SPACE" && !m_held[k]) e_start = 1;
                        if (k == "ESC" && !m_held[k]) e_pause = 1;
                        m_held[k] = 1;
                    end
                end
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle == T) begin
                m_ext = 0; m_brk = 0; m_idle = 0; e_err = 1;
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_p1_up"},   p1_up,   int'(m_held["W"]  && !m_held["S"]));
        chk({pfx, "_p1_down"}, p1_down, int'(m_held["S"]  && !m_held["W"]));
        chk({pfx, "_p2_up"},   p2_up,   int'(m_held["UP"] && !m_held["DN"]));
        chk({pfx, "_p2_down"}, p2_down, int'(m_held["DN"] && !m_held["UP"]));
        chk({pfx, "_start"},   start_pulse, int'(e_start));
        chk({pfx, "_pause"},   pause_pulse, int'(e_pause));
        chk({pfx, "_seq_err"}, seq_error,   int'(e_err));
    endtask

    task automatic cycle(input bit v, input logic [7:0] b);
        byte_valid = v;
        byte_data  = v ? b : 8'($urandom_range(0, 255));
        @(posedge CLK);
        model_step(v, b);
        #1;
        check_outputs("cyc");
        n_start += int'(start_pulse);
        n_pause += int'(pause_pulse);
        n_err   += int'(seq_error);
        byte_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        RST_BTN = 1'b0;
        #2;
        model_reset();
        check_outputs("rst_async");
        @(posedge CLK);
        #1;
        check_outputs("rst_hold");
        RST_BTN = 1'b1;
    endtask

    logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29, 8'h76, 8'hE1, 8'h00};

    initial begin
        model_reset();
        n_start = 0; n_pause = 0; n_err = 0;
        #1;
        do_reset();

        // Make then break of W.
        send(8'h1D); chk("tp1_w_make", p1_up, 1);
        send(8'hF0); chk("tp1_w_after_f0", p1_up, 1);
        send(8'h1D); chk("tp1_w_break", p1_up, 0);

        // Extended up arrow alongside S.
        send(8'hE0); send(8'h75); send(8'h1B);
        chk("tp2_p2_up", p2_up, 1); chk("tp2_p1_down", p1_down, 1);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("tp2_p2_up_rel", p2_up, 0); chk("tp2_p1_down_kept", p1_down, 1);
        send(8'hF0); send(8'h1B);

        // Opposing directions cancel.
        send(8'h1D); send(8'h1B);
        chk("tp3_up_cancel", p1_up, 0); chk("tp3_down_cancel", p1_down, 0);
        send(8'hF0); send(8'h1D);
        chk("tp3_down_alone", p1_down, 1);
        send(8'hF0); send(8'h1B);

        // Typematic Space yields one pulse until released.
        n_start = 0;
        send(8'h29); send(8'h29); send(8'h29);
        chk("tp4_one_pulse", n_start, 1);
        send(8'hF0); send(8'h29); send(8'h29);
        chk("tp4_second_pulse", n_start, 2);
        send(8'hF0); send(8'h29);

        // Dangling E0 times out; plain 75 is unmapped.
        n_err = 0;
        send(8'hE0); idle(T); send(8'h75);
        chk("tp5_one_err", n_err, 1); chk("tp5_p2_up_off", p2_up, 0);

        // Byte on the expiry cycle wins over the timeout.
        n_err = 0;
        send(8'hE0); idle(T - 1); send(8'h75);
        chk("tp5b_no_err", n_err, 0); chk("tp5b_p2_up_on", p2_up, 1);
        send(8'hE0); send(8'hF0); send(8'h75);

        // Reset mid-sequence, then Esc again.
        n_pause = 0;
        send(8'h76); send(8'hF0);
        chk("tp6_pause_before", n_pause, 1);
        do_reset();
        send(8'h76);
        chk("tp6_pause_after", n_pause, 2);
        send(8'hF0); send(8'h76);

        // Randomised traffic, with gaps near the timeout and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else if (r < 5) begin
                idle($urandom_range(T - 2, T + 1));
            end else begin
                logic [7:0] b;
                b = pool[$urandom_range(0, 9)];
                if (b == 8'h00) b = 8'($urandom_range(0, 255));
                cycle($urandom_range(0, 3) != 0, b);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
